fetch_unit: RTL

//  Instruction-fetch stage. Drives the write side of the IF->ID pipeline buffer: owns the PC,

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_pc_gen.sv | 20 ++
 rtl/fetch_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {REQ, HOLD, DROP} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program counter with +4 advance and word-aligned redirect load
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int W = 64,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  output logic [W-1:0] pc
);
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc & ~W'(3);
    else if (advance) pc <= pc + W'(PC_STEP);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage feeding the enable-less IF/ID buffer over a req/ack imem handshake
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N = 32,
  parameter logic [2*N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] NOP = N'(NOP_INSTR)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           redirect,
  input  logic [2*N-1:0] redirect_pc,
  output logic           imem_req,
  output logic [2*N-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [N-1:0]   imem_rdata,
  output logic [2*N-1:0] pc_next,
  output logic [N-1:0]   instruction_next,
  output logic           fetch_valid
);
  fetch_state_t state, state_nx;
  logic [2*N-1:0] pc, drop_addr, last_pc;
  logic [N-1:0] pend_instr, last_instr;
  logic last_valid, advance;
  fetch_pc_gen #(.W(2*N), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .advance(advance),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pc(pc)
  );
  assign advance = !redirect && !stall && ((state == REQ && imem_ack) || state == HOLD);
  assign imem_req = state == REQ || state == DROP;
  assign imem_addr = state == REQ ? pc : state == DROP ? drop_addr : '0;
  always_comb begin
    pc_next = '0;
    instruction_next = NOP;
    fetch_valid = 1'b0;
    if (redirect) begin
      pc_next = '0;
    end else if (stall) begin
      pc_next = last_pc;
      instruction_next = last_instr;
      fetch_valid = last_valid;
    end else if (state == HOLD) begin
      pc_next = pc;
      instruction_next = pend_instr;
      fetch_valid = 1'b1;
    end else if (state == REQ && imem_ack) begin
      pc_next = pc;
      instruction_next = imem_rdata;
      fetch_valid = 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      REQ:     state_nx = redirect ? (imem_ack ? REQ : DROP) : (imem_ack && stall) ? HOLD : REQ;
      HOLD:    state_nx = (redirect || !stall) ? REQ : HOLD;
      DROP:    state_nx = imem_ack ? REQ : DROP;
      default: state_nx = REQ;
    endcase
  end
  // a redirect with the request still open must keep its address until the stale ack lands
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      drop_addr <= '0;
      pend_instr <= NOP;
      last_pc <= '0;
      last_instr <= NOP;
      last_valid <= 1'b0;
    end else begin
      state <= state_nx;
      last_pc <= pc_next;
      last_instr <= instruction_next;
      last_valid <= fetch_valid;
      if (state == REQ && redirect && !imem_ack) drop_addr <= pc;
      if (state == REQ && imem_ack && stall && !redirect) pend_instr <= imem_rdata;
    end
  end
endmodule
